sort4_ctrl: RTL



---
 rtl/sort4_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/sort4_ctrl.sv
// sort4_ctrl: loads a 4-byte frame and sorts it in place through one shared
// 8-bit magnitude comparator. The sort is a fixed 6-step bubble schedule.
// The sorted bytes then stream out over a valid/ready interface.
// DESCEND=0 outputs the smallest byte first; DESCEND=1 outputs the largest first.

// Unsigned 8-bit magnitude comparator. The controller time-shares one instance.
module sort4_cmp (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    output logic       gt_o,
    output logic       lt_o,
    output logic       eq_o
);
    assign gt_o = (a_i > b_i);
    assign lt_o = (a_i < b_i);
    assign eq_o = (a_i == b_i);
endmodule

module sort4_ctrl #(
    parameter logic DESCEND = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       busy,
    output logic [2:0] swap_cnt
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SORT = 2'd1;
    localparam logic [1:0] ST_OUT  = 2'd2;

    logic [1:0] state_q, state_d;
    logic [1:0] ld_idx_q, ld_idx_d;
    logic [1:0] out_idx_q, out_idx_d;
    logic [2:0] step_q, step_d;
    logic [2:0] swap_cnt_q, swap_cnt_d;
    logic [7:0] slot_q [4];
    logic [7:0] slot_d [4];

    logic [1:0] pair_lo;
    logic [1:0] pair_hi;
    logic       cmp_gt, cmp_lt, cmp_eq;
    logic       do_swap;

    // Map each step of the bubble schedule to its lower slot index: 0,1,2,0,1,0
    always_comb begin
        pair_lo = 2'd0;
        case (step_q)
            3'd0: pair_lo = 2'd0;
            3'd1: pair_lo = 2'd1;
            3'd2: pair_lo = 2'd2;
            3'd3: pair_lo = 2'd0;
            3'd4: pair_lo = 2'd1;
            3'd5: pair_lo = 2'd0;
            default: pair_lo = 2'd0;
        endcase
    end

    assign pair_hi = pair_lo + 2'd1;

    sort4_cmp u_cmp (
        .a_i  (slot_q[pair_lo]),
        .b_i  (slot_q[pair_hi]),
        .gt_o (cmp_gt),
        .lt_o (cmp_lt),
        .eq_o (cmp_eq)
    );

    // Equal neighbours never swap, so the sort is stable. The eq term is
    // redundant with gt/lt but makes that rule explicit.
    assign do_swap = !cmp_eq && (DESCEND ? cmp_lt : cmp_gt);

    // Next-state logic for load, sort schedule and drain
    always_comb begin
        state_d    = state_q;
        ld_idx_d   = ld_idx_q;
        out_idx_d  = out_idx_q;
        step_d     = step_q;
        swap_cnt_d = swap_cnt_q;
        for (int k = 0; k < 4; k++) begin
            slot_d[k] = slot_q[k];
        end

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    slot_d[ld_idx_q] = in_data;
                    if (ld_idx_q == 2'd3) begin
                        ld_idx_d   = 2'd0;
                        step_d     = 3'd0;
                        swap_cnt_d = 3'd0;
                        state_d    = ST_SORT;
                    end else begin
                        ld_idx_d = ld_idx_q + 2'd1;
                    end
                end
            end
            ST_SORT: begin
                if (do_swap) begin
                    slot_d[pair_lo] = slot_q[pair_hi];
                    slot_d[pair_hi] = slot_q[pair_lo];
                    swap_cnt_d      = swap_cnt_q + 3'd1;
                end
                if (step_q == 3'd5) begin
                    step_d  = 3'd0;
                    state_d = ST_OUT;
                end else begin
                    step_d = step_q + 3'd1;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    if (out_idx_q == 2'd3) begin
                        out_idx_d = 2'd0;
                        state_d   = ST_IDLE;
                    end else begin
                        out_idx_d = out_idx_q + 2'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and storage registers; reset discards any partial or in-flight frame
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ld_idx_q   <= 2'd0;
            out_idx_q  <= 2'd0;
            step_q     <= 3'd0;
            swap_cnt_q <= 3'd0;
            for (int k = 0; k < 4; k++) begin
                slot_q[k] <= 8'd0;
            end
        end else begin
            state_q    <= state_d;
            ld_idx_q   <= ld_idx_d;
            out_idx_q  <= out_idx_d;
            step_q     <= step_d;
            swap_cnt_q <= swap_cnt_d;
            for (int k = 0; k < 4; k++) begin
                slot_q[k] <= slot_d[k];
            end
        end
    end

    // All outputs decode registered state only; no input-to-output paths
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_OUT);
    assign out_last  = (state_q == ST_OUT) && (out_idx_q == 2'd3);
    assign busy      = (state_q != ST_IDLE);
    assign out_data  = (state_q == ST_OUT) ? slot_q[out_idx_q] : 8'd0;
    assign swap_cnt  = swap_cnt_q;

endmodule
